// File: rtl/yc_pkg.sv
// Shared widths, Q8 colour-matrix coefficient rows and the timing bundle for yc_rgb_matrix.
package yc_pkg;

    localparam int PIX_W  = 8;
    localparam int COEF_W = 9;
    localparam int PROD_W = 17;
    localparam int SUM_W  = 18;
    localparam int C_W    = 9;

    // Index 0 = R, 1 = G, 2 = B; each entry is a two's-complement Q8 coefficient.
    typedef logic [2:0][COEF_W-1:0] coef_row_t;

    typedef struct packed {
        logic ce;
        logic hblank;
        logic hsync;
        logic vblank;
        logic vsync;
    } timing_t;

    function automatic coef_row_t mk_row(input int r, input int g, input int b);
        return {COEF_W'(b), COEF_W'(g), COEF_W'(r)};
    endfunction

    localparam coef_row_t COEF_Y = mk_row(77, 150, 29);
    localparam coef_row_t COEF_I = mk_row(153, -70, -83);
    localparam coef_row_t COEF_Q = mk_row(54, -134, 80);
    localparam coef_row_t COEF_U = mk_row(-38, -74, 112);
    localparam coef_row_t COEF_V = mk_row(157, -131, -26);

    // Unsigned pixel times signed coefficient, both widened to the product width first.
    function automatic logic signed [PROD_W-1:0] mul_pix(input logic [PIX_W-1:0] pix,
                                                         input logic [COEF_W-1:0] coef);
        logic signed [PROD_W-1:0] a;
        logic signed [PROD_W-1:0] b;
        a = {{(PROD_W-PIX_W){1'b0}}, pix};
        b = {{(PROD_W-COEF_W){coef[COEF_W-1]}}, coef};
        return a * b;
    endfunction

endpackage

// File: rtl/yc_mac3.sv
// One matrix row: register three products, sum them, then round, shift by 8 and saturate.
module yc_mac3
    import yc_pkg::*;
#(
    parameter int OUT_W      = 9,
    parameter bit SIGNED_SAT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0][PIX_W-1:0] pix_i,
    input  coef_row_t             coef_i,
    input  logic                  clr_i,
    output logic [OUT_W-1:0]      res_o
);

    localparam logic signed [SUM_W-1:0] SAT_MAX = SIGNED_SAT ? SUM_W'((1 << (OUT_W-1)) - 1)
                                                             : SUM_W'((1 << OUT_W) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SIGNED_SAT ? SUM_W'(-(1 << (OUT_W-1)))
                                                             : SUM_W'(0);
    localparam logic signed [SUM_W-1:0] RND     = SUM_W'(128);

    logic signed [PROD_W-1:0] prod_d [3];
    logic signed [PROD_W-1:0] prod_q [3];
    logic signed [SUM_W-1:0]  sum_d, sum_q;
    logic signed [SUM_W-1:0]  rnd, shifted, clamped;
    logic [OUT_W-1:0]         res_d, res_q;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            prod_d[i] = mul_pix(pix_i[i], coef_i[i]);
        end
        sum_d = SUM_W'(prod_q[0]) + SUM_W'(prod_q[1]) + SUM_W'(prod_q[2]);
    end

    // NOTE: every branch assigns clamped, so no latch is inferred.
    always_comb begin
        rnd     = sum_q + RND;
        shifted = rnd >>> 8;
        if (shifted > SAT_MAX) begin
            clamped = SAT_MAX;
        end else if (shifted < SAT_MIN) begin
            clamped = SAT_MIN;
        end else begin
            clamped = shifted;
        end
        res_d = clr_i ? '0 : OUT_W'(clamped);
    end

    // NOTE: pipeline stages are reset so in-flight pixels are discarded and outputs start at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                prod_q[i] <= '0;
            end
            sum_q <= '0;
            res_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                prod_q[i] <= prod_d[i];
            end
            sum_q <= sum_d;
            res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/yc_rgb_matrix.sv
// RGB to Y/C1/C2 matrix with 3-clk aligned timing and colour-burst gate.
// Burst counter and window compare are built only when YC_BURST_GEN_EN is defined.
module yc_rgb_matrix
    import yc_pkg::*;
#(
    parameter int BURST_START = 8,
    parameter int BURST_LEN   = 18
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pal,
    input  logic                  ce_pix,
    input  logic                  HBlank,
    input  logic                  HSync,
    input  logic                  VBlank,
    input  logic                  VSync,
    input  logic [PIX_W-1:0]      video_r,
    input  logic [PIX_W-1:0]      video_g,
    input  logic [PIX_W-1:0]      video_b,
    output logic                  ce_out,
    output logic                  hblank_o,
    output logic                  hsync_o,
    output logic                  vblank_o,
    output logic                  vsync_o,
    output logic [PIX_W-1:0]      y_o,
    output logic signed [C_W-1:0] c1_o,
    output logic signed [C_W-1:0] c2_o,
    output logic                  burst_en
);

    logic                  pal_q;
    timing_t [2:0]         tim_q;
    timing_t               tim_in;
    logic [2:0][PIX_W-1:0] pix;
    coef_row_t             coef_c1, coef_c2;
    logic                  blank_s2;

    assign tim_in  = timing_t'{ce: ce_pix, hblank: HBlank, hsync: HSync, vblank: VBlank, vsync: VSync};
    assign pix     = {video_b, video_g, video_r};
    assign coef_c1 = pal_q ? COEF_U : COEF_I;
    assign coef_c2 = pal_q ? COEF_V : COEF_Q;
    // Clearing the stage-3 register lands the zeros on the same cycle as the delayed blank.
    assign blank_s2 = tim_q[1].hblank | tim_q[1].vblank;

    // NOTE: registers take non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pal_q <= 1'b0;
            tim_q <= '0;
        end else begin
            pal_q <= pal;
            tim_q <= {tim_q[1:0], tim_in};
        end
    end

    yc_mac3 #(.OUT_W(PIX_W), .SIGNED_SAT(1'b0)) u_y (
        .clk(clk), .rst_n(reset_n), .pix_i(pix), .coef_i(COEF_Y), .clr_i(blank_s2), .res_o(y_o)
    );

    yc_mac3 #(.OUT_W(C_W), .SIGNED_SAT(1'b1)) u_c1 (
        .clk(clk), .rst_n(reset_n), .pix_i(pix), .coef_i(coef_c1), .clr_i(blank_s2), .res_o(c1_o)
    );

    yc_mac3 #(.OUT_W(C_W), .SIGNED_SAT(1'b1)) u_c2 (
        .clk(clk), .rst_n(reset_n), .pix_i(pix), .coef_i(coef_c2), .clr_i(blank_s2), .res_o(c2_o)
    );

    assign ce_out   = tim_q[2].ce;
    assign hblank_o = tim_q[2].hblank;
    assign hsync_o  = tim_q[2].hsync;
    assign vblank_o = tim_q[2].vblank;
    assign vsync_o  = tim_q[2].vsync;

    // The window must close before the counter parks at its idle value.
    if (BURST_START + BURST_LEN > 63) begin : g_burst_cfg_check
        $error("yc_rgb_matrix: BURST_START + BURST_LEN must not exceed 63");
    end

`ifdef YC_BURST_GEN_EN
    localparam logic [6:0] WIN_LO = 7'(BURST_START);
    localparam logic [6:0] WIN_HI = 7'(BURST_START + BURST_LEN);

    logic [5:0] cnt_d, cnt_q;
    logic       hs_prev_q;
    logic       burst_d, burst_q;

    always_comb begin
        cnt_d = cnt_q;
        if (hs_prev_q && !tim_q[2].hsync) begin
            cnt_d = '0;
        end else if (tim_q[2].ce && (cnt_q != 6'd63)) begin
            cnt_d = cnt_q + 6'd1;
        end
        burst_d = ({1'b0, cnt_q} >= WIN_LO) && ({1'b0, cnt_q} < WIN_HI) && !tim_q[2].vsync;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= 6'd63;
            hs_prev_q <= 1'b0;
            burst_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hs_prev_q <= tim_q[2].hsync;
            burst_q   <= burst_d;
        end
    end

    assign burst_en = burst_q;
`else
    assign burst_en = 1'b0;
`endif

endmodule

// File: tb/tb_yc_rgb_matrix.sv
// Scoreboard bench for yc_rgb_matrix: expected outputs are queued as stimulus is driven and
// popped three clocks later; burst expectation follows YC_BURST_GEN_EN.
module tb_yc_rgb_matrix;

    localparam int B_START = 8;
    localparam int B_LEN   = 18;

    typedef struct {
        int y;
        int c1;
        int c2;
        bit ce;
        bit hb;
        bit hs;
        bit vb;
        bit vs;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              pal = 1'b0;
    logic              ce_pix = 1'b0;
    logic              HBlank = 1'b0;
    logic              HSync = 1'b0;
    logic              VBlank = 1'b0;
    logic              VSync = 1'b0;
    logic [7:0]        video_r = '0;
    logic [7:0]        video_g = '0;
    logic [7:0]        video_b = '0;
    logic              ce_out, hblank_o, hsync_o, vblank_o, vsync_o, burst_en;
    logic [7:0]        y_o;
    logic signed [8:0] c1_o, c2_o;

    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;
    int   burst_cycles = 0;
    exp_t sb[$];

    // Reference burst counter and delayed pal, rebuilt from the expected stream.
    int m_cnt = 63;
    bit m_hs_prev = 1'b0;
    bit m_burst = 1'b0;
    bit m_pal = 1'b0;

    yc_rgb_matrix #(.BURST_START(B_START), .BURST_LEN(B_LEN)) dut (
        .clk(clk), .reset_n(reset_n), .pal(pal), .ce_pix(ce_pix),
        .HBlank(HBlank), .HSync(HSync), .VBlank(VBlank), .VSync(VSync),
        .video_r(video_r), .video_g(video_g), .video_b(video_b),
        .ce_out(ce_out), .hblank_o(hblank_o), .hsync_o(hsync_o), .vblank_o(vblank_o),
        .vsync_o(vsync_o), .y_o(y_o), .c1_o(c1_o), .c2_o(c2_o), .burst_en(burst_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Round-half-up of s/256 by floor division, then clamp.
    function automatic int q8(input int s, input int lo, input int hi);
        int t;
        int q;
        t = s + 128;
        q = t / 256;
        if (t < 0 && (t % 256) != 0) q = q - 1;
        if (q < lo) q = lo;
        if (q > hi) q = hi;
        return q;
    endfunction

    function automatic exp_t model(input bit p, input bit ce, input bit hb, input bit hs,
                                   input bit vb, input bit vs, input int r, input int g,
                                   input int b);
        exp_t e;
        int   s1;
        int   s2;
        e.ce = ce; e.hb = hb; e.hs = hs; e.vb = vb; e.vs = vs;
        if (!p) begin
            s1 = 153*r - 70*g - 83*b;
            s2 = 54*r - 134*g + 80*b;
        end else begin
            s1 = -38*r - 74*g + 112*b;
            s2 = 157*r - 131*g - 26*b;
        end
        if (hb || vb) begin
            e.y = 0; e.c1 = 0; e.c2 = 0;
        end else begin
            e.y  = q8(77*r + 150*g + 29*b, 0, 255);
            e.c1 = q8(s1, -256, 255);
            e.c2 = q8(s2, -256, 255);
        end
        return e;
    endfunction

    function automatic exp_t zero_exp();
        return model(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_y"}, y_o, 0);
        check({tag, "_c1"}, c1_o, 0);
        check({tag, "_c2"}, c2_o, 0);
        check({tag, "_ce"}, ce_out, 0);
        check({tag, "_hblank"}, hblank_o, 0);
        check({tag, "_hsync"}, hsync_o, 0);
        check({tag, "_vblank"}, vblank_o, 0);
        check({tag, "_vsync"}, vsync_o, 0);
        check({tag, "_burst"}, burst_en, 0);
    endtask

    // Assert reset between edges, check outputs at once, then release with an idle pipeline.
    task automatic do_reset(input string tag);
        #2 reset_n = 1'b0;
        #1 check_all_zero(tag);
        pal = 1'b0; ce_pix = 1'b0; HBlank = 1'b0; HSync = 1'b0; VBlank = 1'b0; VSync = 1'b0;
        video_r = '0; video_g = '0; video_b = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        sb.delete();
        repeat (3) sb.push_back(zero_exp());
        m_cnt = 63; m_hs_prev = 1'b0; m_burst = 1'b0; m_pal = 1'b0;
    endtask

    // One clock: compare what the DUT shows now, then drive the next input sample.
    task automatic step(input bit p, input bit ce, input bit hb, input bit hs, input bit vb,
                        input bit vs, input int r, input int g, input int b);
        exp_t cur;
        bit   exp_burst;
        bit   fall;
        @(negedge clk);
        step_no++;
        cur = sb.pop_front();
        check($sformatf("y@%0d", step_no), y_o, cur.y);
        check($sformatf("c1@%0d", step_no), c1_o, cur.c1);
        check($sformatf("c2@%0d", step_no), c2_o, cur.c2);
        check($sformatf("ce_out@%0d", step_no), ce_out, cur.ce);
        check($sformatf("hblank_o@%0d", step_no), hblank_o, cur.hb);
        check($sformatf("hsync_o@%0d", step_no), hsync_o, cur.hs);
        check($sformatf("vblank_o@%0d", step_no), vblank_o, cur.vb);
        check($sformatf("vsync_o@%0d", step_no), vsync_o, cur.vs);
`ifdef YC_BURST_GEN_EN
        exp_burst = m_burst;
`else
        exp_burst = 1'b0;
`endif
        check($sformatf("burst_en@%0d", step_no), burst_en, exp_burst);
        if (burst_en === 1'b1) burst_cycles++;

        fall      = m_hs_prev && !cur.hs;
        m_burst   = (m_cnt >= B_START) && (m_cnt < B_START + B_LEN) && !cur.vs;
        if (fall) m_cnt = 0;
        else if (cur.ce && m_cnt < 63) m_cnt = m_cnt + 1;
        m_hs_prev = cur.hs;

        pal = p; ce_pix = ce; HBlank = hb; HSync = hs; VBlank = vb; VSync = vs;
        video_r = 8'(r); video_g = 8'(g); video_b = 8'(b);
        sb.push_back(model(m_pal, ce, hb, hs, vb, vs, r, g, b));
        m_pal = p;
    endtask

    task automatic flush();
        repeat (3) step(pal, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        int exp_len;
        do_reset("reset");

        // Matrix: white, primaries, standard switch, greys, blanking.
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 255, 255, 255);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 255, 0, 0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 255, 0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16, 16, 16);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 191, 191, 191);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16, 16, 16);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 191, 191, 191);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 255, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 255);
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 255, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 255, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 255);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 255, 255, 0);
        flush();

        // Burst window: ce every other clk, one HSync pulse.
`ifdef YC_BURST_GEN_EN
        exp_len = 2 * B_LEN;
`else
        exp_len = 0;
`endif
        burst_cycles = 0;
        for (int i = 0; i < 90; i++) begin
            step(1'b0, 1'(i % 2), 1'b0, 1'(i >= 2 && i < 6), 1'b0, 1'b0, 100, 100, 100);
        end
        check("burst_high_cycles", burst_cycles, exp_len);

        // Same line with VSync held high: no burst.
        burst_cycles = 0;
        for (int i = 0; i < 90; i++) begin
            step(1'b0, 1'(i % 2), 1'b0, 1'(i >= 2 && i < 6), 1'b0, 1'b1, 100, 100, 100);
        end
        check("burst_vsync_cycles", burst_cycles, 0);

        // Reset mid-line with data and an open burst window in flight.
        burst_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'(i % 2), 1'b0, 1'(i >= 2 && i < 6), 1'b0, 1'b0, 200, 50, 100);
        end
        check("burst_before_reset", (burst_cycles > 0) ? 1 : 0, (exp_len > 0) ? 1 : 0);
        do_reset("midline_reset");
        burst_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'(i % 2), 1'b0, 1'b0, 1'b0, 1'b0, 200, 50, 100);
        end
        flush();
        check("burst_idle_after_reset", burst_cycles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
